roundkey_gen_multi: RTL and testbench

Parametrised AES key-expansion step engine for AES-128, AES-192 and AES-256. Each start computes the next Nk expanded words (Nk = 4, 6 or 8) from a window of the previous Nk words. It drives a shared, externally owned S-box with 1, 2 or 4 byte lanes per access. It sits between the cipher core's key-window register and the shared S-box arbiter, and replaces the single-lane, 4-word-per-step generator.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/roundkey_gen_multi_if.sv | 27 ++
 rtl/word_chain_xor.sv | 20 ++
 rtl/roundkey_gen_multi.sv | 171 +++++++++++++++++
 tb/tb_roundkey_gen_multi.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encodings, FSM states and
// the small word-level helpers used by the key-expansion step engines.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'd0,
    AES192 = 2'd1,
    AES256 = 2'd2
  } aes_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } rk_state_e;

  // Round constant in the most significant byte; out-of-range indices give zero.
  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Mode 3 is not a real key length and falls back to AES-128.
  function automatic int nk(input logic [1:0] m);
    case (m)
      AES192:  return 6;
      AES256:  return 8;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/roundkey_gen_multi_if.sv
// Key-window request/response plus the shared S-box access port of one
// key-expansion step engine; slave is the engine, master its surroundings.
interface roundkey_gen_multi_if #(parameter int SBOX_LANES = 1);

  logic [1:0]              mode;
  logic [255:0]            win;
  logic [3:0]              rcon_idx_in;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [255:0]            wout;
  logic [3:0]              rcon_idx_out;
  logic                    sbox_en;
  logic [8*SBOX_LANES-1:0] sbox_in;
  logic [8*SBOX_LANES-1:0] sbox_out;

  modport master (
    output mode, win, rcon_idx_in, start, sbox_out,
    input  busy, done, wout, rcon_idx_out, sbox_en, sbox_in
  );

  modport slave (
    input  mode, win, rcon_idx_in, start, sbox_out,
    output busy, done, wout, rcon_idx_out, sbox_en, sbox_in
  );

endinterface

// File: rtl/word_chain_xor.sv
// Combinational running XOR: n[0] = w[0] ^ seed, n[k] = w[k] ^ n[k-1].
// Index 0 is the first word of the chain.
module word_chain_xor (
  input  logic [31:0]      seed,
  input  logic [3:0][31:0] w,
  output logic [3:0][31:0] n
);

  logic [31:0] acc;

  always_comb begin
    acc = seed;
    n   = '0;
    for (int k = 0; k < 4; k++) begin
      acc  = acc ^ w[k];
      n[k] = acc;
    end
  end

endmodule

// File: rtl/roundkey_gen_multi.sv
// AES-128/192/256 key-expansion step: next Nk words from the previous Nk, done after
// 2G+1 edges (4G+1 for AES-256), G = 4/SBOX_LANES; new starts ignored while busy.
module roundkey_gen_multi
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  roundkey_gen_multi_if.slave bus
);

  localparam int G  = 4 / SBOX_LANES;
  localparam int LW = 8 * SBOX_LANES;

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("roundkey_gen_multi: SBOX_LANES must be 1, 2 or 4");
  end

  rk_state_e   state;
  logic [1:0]  mode_r;
  logic [3:0]  rcon_r;
  logic [31:0] w_r [8];
  logic [31:0] n_r [8];
  logic [31:0] src;
  logic [31:0] sub;
  logic [1:0]  grp;
  logic        phase_sub;

  logic          busy_r;
  logic          done_r;
  logic [255:0]  wout_r;
  logic [3:0]    rcon_out_r;
  logic          sbox_en_r;
  logic [LW-1:0] sbox_in_r;

  logic [31:0]      sub_nxt;
  logic [31:0]      seed_a;
  logic [31:0]      seed_b;
  logic [3:0][31:0] wa;
  logic [3:0][31:0] wb;
  logic [3:0][31:0] chain_a;
  logic [3:0][31:0] chain_b;

  // Completion decisions use sub with the byte group arriving this cycle merged in.
  always_comb begin
    sub_nxt = sub;
    sub_nxt[31 - LW*int'(grp) -: LW] = bus.sbox_out;
  end

  always_comb begin
    wa = '0;
    wb = '0;
    for (int k = 0; k < 4; k++) begin
      wa[k] = w_r[k];
      wb[k] = w_r[k+4];
    end
    seed_a = sub_nxt ^ rcon(rcon_r);
    // Phase 0 continues the first chain (AES-192 n4/n5); phase 1 starts from SubWord(n3).
    seed_b = phase_sub ? sub_nxt : chain_a[3];
  end

  word_chain_xor u_chain_lo (
    .seed (seed_a),
    .w    (wa),
    .n    (chain_a)
  );

  word_chain_xor u_chain_hi (
    .seed (seed_b),
    .w    (wb),
    .n    (chain_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_r     <= '0;
      rcon_r     <= '0;
      src        <= '0;
      sub        <= '0;
      grp        <= '0;
      phase_sub  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wout_r     <= '0;
      rcon_out_r <= '0;
      sbox_en_r  <= 1'b0;
      sbox_in_r  <= '0;
      for (int k = 0; k < 8; k++) begin
        w_r[k] <= '0;
        n_r[k] <= '0;
      end
    end else begin
      done_r    <= 1'b0;
      sbox_en_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_r <= bus.mode;
            rcon_r <= bus.rcon_idx_in;
            for (int k = 0; k < 8; k++) begin
              w_r[k] <= bus.win[255-32*k -: 32];
            end
            src       <= rotword(bus.win[255 - 32*(nk(bus.mode)-1) -: 32]);
            phase_sub <= 1'b0;
            grp       <= '0;
            busy_r    <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          sbox_in_r <= src[31 - LW*int'(grp) -: LW];
          sbox_en_r <= 1'b1;
          state     <= CAPTURE;
        end

        CAPTURE: begin
          sub <= sub_nxt;
          if (grp != 2'(G-1)) begin
            grp   <= grp + 2'd1;
            state <= ISSUE;
          end else if (!phase_sub) begin
            for (int k = 0; k < 4; k++) begin
              n_r[k] <= chain_a[k];
            end
            if (nk(mode_r) == 6) begin
              n_r[4] <= chain_b[0];
              n_r[5] <= chain_b[1];
            end
            if (nk(mode_r) == 8) begin
              // Second SubWord of AES-256 works on n3 as-is: no rotation, no Rcon.
              src       <= chain_a[3];
              phase_sub <= 1'b1;
              grp       <= '0;
              state     <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end else begin
            for (int k = 0; k < 4; k++) begin
              n_r[k+4] <= chain_b[k];
            end
            state <= FINISH;
          end
        end

        FINISH: begin
          for (int k = 0; k < 8; k++) begin
            wout_r[255-32*k -: 32] <= (k < nk(mode_r)) ? n_r[k] : 32'h0;
          end
          rcon_out_r <= rcon_r + 4'd1;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.wout         = wout_r;
  assign bus.rcon_idx_out = rcon_out_r;
  assign bus.sbox_en      = sbox_en_r;
  assign bus.sbox_in      = sbox_in_r;

endmodule

// File: tb/tb_roundkey_gen_multi.sv
// Directed bench for roundkey_gen_multi at 1, 2 and 4 S-box lanes against FIPS-197 vectors.
module tb_roundkey_gen_multi;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  localparam logic [255:0] K128 = {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 128'h0};
  localparam logic [255:0] E128 = {32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605, 128'h0};
  localparam logic [255:0] R9   = {32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e, 128'h0};
  localparam logic [255:0] R10  = {32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6, 128'h0};
  localparam logic [255:0] K192 = {32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                                   32'h62f8ead2, 32'h522c6b7b, 64'h0};
  localparam logic [255:0] E192 = {32'hfe0c91f7, 32'h2402f5a5, 32'hec12068e, 32'h6c827f6b,
                                   32'h0e7a95b9, 32'h5c56fec2, 64'h0};
  localparam logic [255:0] K256 = {32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                                   32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
  localparam logic [255:0] E256 = {32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde,
                                   32'ha8b09c1a, 32'h93d194cd, 32'hbe49846e, 32'hb75d5b9a};

  roundkey_gen_multi_if #(.SBOX_LANES(1)) b1 ();
  roundkey_gen_multi_if #(.SBOX_LANES(2)) b2 ();
  roundkey_gen_multi_if #(.SBOX_LANES(4)) b4 ();

  roundkey_gen_multi #(.SBOX_LANES(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  roundkey_gen_multi #(.SBOX_LANES(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  roundkey_gen_multi #(.SBOX_LANES(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference S-box built from the GF(2^8) inverse and the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, e, inv;
    r = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e    = {1'b0, e[7:1]};
    end
    inv = (x == 8'h00) ? 8'h00 : r;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign b1.sbox_out = sbox(b1.sbox_in);
  assign b2.sbox_out = {sbox(b2.sbox_in[15:8]), sbox(b2.sbox_in[7:0])};
  assign b4.sbox_out = {sbox(b4.sbox_in[31:24]), sbox(b4.sbox_in[23:16]),
                        sbox(b4.sbox_in[15:8]), sbox(b4.sbox_in[7:0])};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b1.busy, b2.busy, b4.busy} !== 3'b000) begin
      fails++; $display("FAIL reset_busy: got %b want 000", {b1.busy, b2.busy, b4.busy});
    end
    checks++;
    if ({b1.done, b2.done, b4.done} !== 3'b000) begin
      fails++; $display("FAIL reset_done: got %b want 000", {b1.done, b2.done, b4.done});
    end
    checks++;
    if ((b1.wout | b2.wout | b4.wout) !== 256'h0) begin
      fails++; $display("FAIL reset_wout: got %h want 0", b1.wout | b2.wout | b4.wout);
    end
    checks++;
    if ((b1.rcon_idx_out | b2.rcon_idx_out | b4.rcon_idx_out) !== 4'h0) begin
      fails++; $display("FAIL reset_rcon: got %h want 0", b1.rcon_idx_out | b2.rcon_idx_out | b4.rcon_idx_out);
    end
    checks++;
    if ({b1.sbox_en, b2.sbox_en, b4.sbox_en, b1.sbox_in, b2.sbox_in, b4.sbox_in} !== 59'h0) begin
      fails++; $display("FAIL reset_sbox: got en %b%b%b in %h %h %h want 0", b1.sbox_en, b2.sbox_en,
                        b4.sbox_en, b1.sbox_in, b2.sbox_in, b4.sbox_in);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_aes128_l1();
    int cyc;
    b1.mode = 2'd0; b1.win = K128; b1.rcon_idx_in = 4'd0; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    checks++;
    if (b1.busy !== 1'b1) begin
      fails++; $display("FAIL a128_busy_after_start: got %b want 1", b1.busy);
    end
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!b1.done && cyc < 40);
    checks++;
    if (cyc !== 9) begin
      fails++; $display("FAIL a128_latency: got %0d want 9", cyc);
    end
    checks++;
    if (b1.wout !== E128) begin
      fails++; $display("FAIL a128_wout: got %h want %h", b1.wout, E128);
    end
    checks++;
    if (b1.rcon_idx_out !== 4'd1) begin
      fails++; $display("FAIL a128_rcon_out: got %0d want 1", b1.rcon_idx_out);
    end
    checks++;
    if (b1.busy !== 1'b0) begin
      fails++; $display("FAIL a128_busy_in_done: got %b want 0", b1.busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({b1.done, b1.wout} !== {1'b0, E128}) begin
      fails++; $display("FAIL a128_pulse_hold: got done %b wout %h want done 0 wout %h", b1.done, b1.wout, E128);
    end
  endtask

  task automatic test_aes192_l2();
    int cyc;
    b2.mode = 2'd1; b2.win = K192; b2.rcon_idx_in = 4'd0; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!b2.done && cyc < 40);
    checks++;
    if (cyc !== 5) begin
      fails++; $display("FAIL a192_latency: got %0d want 5", cyc);
    end
    checks++;
    if (b2.wout !== E192) begin
      fails++; $display("FAIL a192_wout: got %h want %h", b2.wout, E192);
    end
    checks++;
    if (b2.rcon_idx_out !== 4'd1) begin
      fails++; $display("FAIL a192_rcon_out: got %0d want 1", b2.rcon_idx_out);
    end
  endtask

  task automatic test_aes256_l4();
    int cyc;
    b4.mode = 2'd2; b4.win = K256; b4.rcon_idx_in = 4'd0; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!b4.done && cyc < 40);
    checks++;
    if (cyc !== 5) begin
      fails++; $display("FAIL a256_latency: got %0d want 5", cyc);
    end
    checks++;
    if (b4.wout !== E256) begin
      fails++; $display("FAIL a256_wout: got %h want %h", b4.wout, E256);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, total, bad_steps;
    total = 0; bad_steps = 0;
    b1.mode = 2'd0; b1.win = K128; b1.rcon_idx_in = 4'd0; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    for (int step = 0; step < 10; step++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1; cyc++; total++;
      end while (!b1.done && cyc < 40);
      if (cyc != 9) bad_steps++;
      if (step == 8) begin
        checks++;
        if (b1.wout !== R9) begin
          fails++; $display("FAIL chain_round9: got %h want %h", b1.wout, R9);
        end
      end
      if (step < 9) begin
        b1.win = b1.wout; b1.rcon_idx_in = b1.rcon_idx_out; b1.start = 1'b1;
        @(posedge clk); #1; total++;
        b1.start = 1'b0;
      end
    end
    checks++;
    if (bad_steps !== 0) begin
      fails++; $display("FAIL chain_step_latency: got %0d bad steps want 0", bad_steps);
    end
    checks++;
    if (total !== 99) begin
      fails++; $display("FAIL chain_total_cycles: got %0d want 99", total);
    end
    checks++;
    if (b1.wout !== R10) begin
      fails++; $display("FAIL chain_round10: got %h want %h", b1.wout, R10);
    end
    checks++;
    if (b1.rcon_idx_out !== 4'd10) begin
      fails++; $display("FAIL chain_rcon_out: got %0d want 10", b1.rcon_idx_out);
    end
  endtask

  task automatic test_busy_start_mode3();
    int cyc;
    b1.mode = 2'd3; b1.win = K128; b1.rcon_idx_in = 4'd0; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b1.mode = 2'd2; b1.win = K256; b1.rcon_idx_in = 4'd9;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      b1.start = (cyc == 3);
    end while (!b1.done && cyc < 40);
    b1.start = 1'b0;
    checks++;
    if (cyc !== 9) begin
      fails++; $display("FAIL busy_start_latency: got %0d want 9", cyc);
    end
    checks++;
    if (b1.wout !== E128) begin
      fails++; $display("FAIL mode3_wout: got %h want %h", b1.wout, E128);
    end
    checks++;
    if (b1.rcon_idx_out !== 4'd1) begin
      fails++; $display("FAIL mode3_rcon_out: got %0d want 1", b1.rcon_idx_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_step();
    int  cyc;
    bit  seen_done;
    b1.mode = 2'd0; b1.win = K128; b1.rcon_idx_in = 4'd0; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b1.busy, b1.sbox_en} !== 2'b11) begin
      fails++; $display("FAIL midrst_pre: got busy %b en %b want 1 1", b1.busy, b1.sbox_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b1.busy, b1.done, b1.sbox_en} !== 3'b000) begin
      fails++; $display("FAIL midrst_flags: got %b want 000", {b1.busy, b1.done, b1.sbox_en});
    end
    checks++;
    if ({b1.wout, b1.rcon_idx_out, b1.sbox_in} !== 268'h0) begin
      fails++; $display("FAIL midrst_data: got wout %h rcon %h in %h want 0", b1.wout, b1.rcon_idx_out, b1.sbox_in);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b1.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      fails++; $display("FAIL midrst_no_done: got %b want 0", seen_done);
    end
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!b1.done && cyc < 40);
    checks++;
    if ({cyc == 9, b1.wout} !== {1'b1, E128}) begin
      fails++; $display("FAIL midrst_restart: got cyc %0d wout %h want cyc 9 wout %h", cyc, b1.wout, E128);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    b1.mode = '0; b1.win = '0; b1.rcon_idx_in = '0; b1.start = 1'b0;
    b2.mode = '0; b2.win = '0; b2.rcon_idx_in = '0; b2.start = 1'b0;
    b4.mode = '0; b4.win = '0; b4.rcon_idx_in = '0; b4.start = 1'b0;
    test_reset();
    test_aes128_l1();
    test_aes192_l2();
    test_aes256_l4();
    test_back_to_back();
    test_busy_start_mode3();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
